axil_cmd_master: RTL and testbench

// - AXI4-Lite initiator: turns single-word commands from a local requester (DMA, test sequencer) into AXI4-Lite read/write transactions.
// - Sits between an internal command port and any AXI4-Lite RAM/register slave.
// - One outstanding transaction at a time; result returned on a handshaked response port.

---
 rtl/axil_cmd_master_if.sv | 44 ++++
 rtl/axil_cmd_master.sv | 179 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_cmd_master_if
// Purpose  : AXI4-Lite bus bundle (32-bit data) with master/slave modports.
// Revision : 1.0 - initial release
// ============================================================================
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_cmd_master
// Purpose  : single-outstanding AXI4-Lite initiator driven by a command port;
//            optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    input  wire logic                  cmd_write,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [31:0]           cmd_wdata,
    input  wire logic [3:0]            cmd_wstrb,
    output logic                       rsp_valid,
    input  wire logic                  rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_timeout,
    axil_cmd_master_if.master          m_axil
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WR_B  = 3'd2,
        S_RD_AR = 3'd3,
        S_RD_R  = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            r_rsp_resp;

    logic w_accept;
    logic w_wr_go;
    logic w_b_go;
    logic w_ar_go;
    logic w_r_go;
    logic w_tmo;
    logic w_abort;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    // AW and W retire independently; a channel already done counts as ready
    assign w_wr_go  = (r_state == S_WR) &&
                      (!r_aw_pend || m_axil.awready) &&
                      (!r_w_pend  || m_axil.wready);
    assign w_b_go   = (r_state == S_WR_B)  && m_axil.bvalid;
    assign w_ar_go  = (r_state == S_RD_AR) && m_axil.arready;
    assign w_r_go   = (r_state == S_RD_R)  && m_axil.rvalid;
    // A handshake landing on the watchdog's last cycle still wins
    assign w_abort  = w_tmo && !(w_wr_go || w_b_go || w_ar_go || w_r_go);

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LIM  = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_rsp_timeout;
    logic               w_busy;

    assign w_busy = (r_state == S_WR)    || (r_state == S_WR_B) ||
                    (r_state == S_RD_AR) || (r_state == S_RD_R);
    assign w_tmo  = w_busy && (r_tmo_cnt >= c_TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tmo_cnt <= '0;
            end else if (w_busy && (r_tmo_cnt != c_TMO_LIM)) begin
                r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
            end
            if (w_b_go || w_r_go) begin
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_tmo       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = cmd_write ? S_WR : S_RD_AR;
            S_WR:    if (w_wr_go) w_state_nxt = S_WR_B;
                     else if (w_abort) w_state_nxt = S_RSP;
            S_WR_B:  if (w_b_go || w_abort) w_state_nxt = S_RSP;
            S_RD_AR: if (w_ar_go) w_state_nxt = S_RD_R;
                     else if (w_abort) w_state_nxt = S_RSP;
            S_RD_R:  if (w_r_go || w_abort) w_state_nxt = S_RSP;
            S_RSP:   if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_pend   <= 1'b0;
            r_w_pend    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_pend <= cmd_write;
                r_w_pend  <= cmd_write;
            end else if (w_abort) begin
                r_aw_pend <= 1'b0;
                r_w_pend  <= 1'b0;
            end else if (r_state == S_WR) begin
                if (m_axil.awready) r_aw_pend <= 1'b0;
                if (m_axil.wready)  r_w_pend  <= 1'b0;
            end

            if (w_b_go) begin
                r_rsp_rdata <= '0;
                r_rsp_resp  <= m_axil.bresp;
            end else if (w_r_go) begin
                r_rsp_rdata <= m_axil.rdata;
                r_rsp_resp  <= m_axil.rresp;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_resp  <= 2'b10;
            end
        end
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign rsp_valid      = (r_state == S_RSP);
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;

    assign m_axil.awaddr  = r_addr;
    assign m_axil.awvalid = (r_state == S_WR) && r_aw_pend;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = (r_state == S_WR) && r_w_pend;
    assign m_axil.bready  = (r_state == S_WR_B);
    assign m_axil.araddr  = r_addr;
    assign m_axil.arvalid = (r_state == S_RD_AR);
    assign m_axil.rready  = (r_state == S_RD_R);

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_cmd_master
// Purpose  : self-checking bench: RAM slave with programmable ready delays,
//            table vectors, corner-case sequences and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_cmd_master;
    localparam int c_TMO = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axil_cmd_master_if #(.ADDR_WIDTH(32)) axil ();

    axil_cmd_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(c_TMO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil(axil)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- slave RAM with per-channel wait knobs ----------------
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          ar_never = 1'b0;
    logic [1:0]  resp_code = 2'b00;
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    int          sl_aw_cnt = 0, sl_w_cnt = 0, sl_ar_cnt = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, reassert = 0, aw_hi = 0, w_hi = 0;
    logic [31:0] aw_seen = '0, ar_seen = '0, aw_a = '0, w_d = '0;
    logic [3:0]  w_s = '0;
    logic        aw_got = 1'b0, w_got = 1'b0;

    assign axil.awready = axil.awvalid && (sl_aw_cnt >= aw_wait);
    assign axil.wready  = axil.wvalid  && (sl_w_cnt  >= w_wait);
    assign axil.arready = axil.arvalid && !ar_never && (sl_ar_cnt >= ar_wait);

    logic        sl_aw_hs, sl_w_hs, sl_ar_hs, sl_ad, sl_wd;
    logic [31:0] sl_a, sl_d;
    logic [3:0]  sl_s;
    assign sl_aw_hs = axil.awvalid && axil.awready;
    assign sl_w_hs  = axil.wvalid && axil.wready;
    assign sl_ar_hs = axil.arvalid && axil.arready;
    assign sl_ad    = aw_got || sl_aw_hs;
    assign sl_wd    = w_got || sl_w_hs;
    assign sl_a     = aw_got ? aw_a : axil.awaddr;
    assign sl_d     = w_got ? w_d : axil.wdata;
    assign sl_s     = w_got ? w_s : axil.wstrb;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if (!mem_loaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A50000 + i;
                mem_loaded <= 1'b1;
            end
            aw_got <= 1'b0; w_got <= 1'b0;
            axil.bvalid <= 1'b0; axil.bresp <= '0;
            axil.rvalid <= 1'b0; axil.rdata <= '0; axil.rresp <= '0;
            sl_aw_cnt <= 0; sl_w_cnt <= 0; sl_ar_cnt <= 0;
        end else begin
            if (axil.awvalid) aw_hi <= aw_hi + 1;
            if (axil.wvalid)  w_hi  <= w_hi + 1;
            if (sl_aw_hs) begin aw_hs <= aw_hs + 1; aw_seen <= axil.awaddr; sl_aw_cnt <= 0; end
            else if (axil.awvalid) sl_aw_cnt <= sl_aw_cnt + 1;
            else sl_aw_cnt <= 0;
            if (sl_w_hs) begin w_hs <= w_hs + 1; sl_w_cnt <= 0; end
            else if (axil.wvalid) sl_w_cnt <= sl_w_cnt + 1;
            else sl_w_cnt <= 0;
            if ((axil.awvalid && aw_got) || (axil.wvalid && w_got)) reassert <= reassert + 1;

            if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;

            if (sl_ad && sl_wd) begin
                for (int b = 0; b < 4; b++)
                    if (sl_s[b]) mem[sl_a[9:2]][8*b +: 8] <= sl_d[8*b +: 8];
                axil.bvalid <= 1'b1;
                axil.bresp  <= resp_code;
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (sl_aw_hs) begin aw_got <= 1'b1; aw_a <= axil.awaddr; end
                if (sl_w_hs)  begin w_got <= 1'b1; w_d <= axil.wdata; w_s <= axil.wstrb; end
            end

            if (sl_ar_hs) begin
                ar_hs <= ar_hs + 1; ar_seen <= axil.araddr; sl_ar_cnt <= 0;
                axil.rvalid <= 1'b1;
                axil.rdata  <= mem[axil.araddr[9:2]];
                axil.rresp  <= resp_code;
            end else if (axil.arvalid) sl_ar_cnt <= sl_ar_cnt + 1;
            else sl_ar_cnt <= 0;
        end
    end

    // ---------------- reference model: word array + byte-strobe merge ----------------
    logic [31:0] mdl [256];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- command driver ----------------
    int          g_lat;
    logic [31:0] g_rdata;
    logic [1:0]  g_resp;
    logic        g_tmo;
    logic [4:0]  g_axi_at_rsp;
    bit          g_stall_bad;

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int hold);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!cmd_ready) chk("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        g_lat = 1;
        while (!rsp_valid && g_lat < 200) begin @(posedge clk); #1; g_lat++; end
        if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 32'd1);
        g_rdata = rsp_rdata; g_resp = rsp_resp; g_tmo = rsp_timeout;
        g_axi_at_rsp = {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready};
        g_stall_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            if (!rsp_valid || cmd_ready || rsp_rdata !== g_rdata || rsp_resp !== g_resp ||
                rsp_timeout !== g_tmo) g_stall_bad = 1'b1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Full transaction checked against the model and the slave's channel counters
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input int hold);
        int aw0, w0, ar0, re0, exp_lat;
        logic [31:0] exp_rd;
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; re0 = reassert;
        exp_rd  = wr ? 32'h0 : mdl[addr[9:2]];
        exp_lat = wr ? ((aw_wait > w_wait ? aw_wait : w_wait) + 3) : (ar_wait + 3);
        run_cmd(wr, addr, wd, strb, hold);
        if (wr) mdl[addr[9:2]] = merge(mdl[addr[9:2]], wd, strb);
        chk("rdata",    g_rdata, exp_rd);
        chk("resp",     32'(g_resp), 32'(resp_code));
        chk("timeout",  32'(g_tmo), 32'd0);
        chk("latency",  32'(g_lat), 32'(exp_lat));
        chk("axi_idle_at_rsp", 32'(g_axi_at_rsp), 32'd0);
        chk("aw_count", 32'(aw_hs - aw0), wr ? 32'd1 : 32'd0);
        chk("w_count",  32'(w_hs - w0),   wr ? 32'd1 : 32'd0);
        chk("ar_count", 32'(ar_hs - ar0), wr ? 32'd0 : 32'd1);
        chk("no_reassert", 32'(reassert - re0), 32'd0);
        chk("bus_addr", wr ? aw_seen : ar_seen, addr);
        if (hold > 0) chk("rsp_stall_stable", 32'(g_stall_bad), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : p_main
        int aw0, w0, awh0, wh0, lat_exp;
        bit bad;
        for (int i = 0; i < 256; i++) mdl[i] = 32'hA5A50000 + i;

        tbl[0] = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hA5A50004};
        tbl[1] = '{1'b1, 32'h20,  32'hDEADBEEF, 4'b0011, 32'h0};
        tbl[2] = '{1'b0, 32'h20,  32'h0,        4'b0000, 32'hA5A5BEEF};
        tbl[3] = '{1'b0, 32'h0,   32'h0,        4'b0000, 32'hA5A50000};
        tbl[4] = '{1'b1, 32'h3FC, 32'h12345678, 4'b1111, 32'h0};
        tbl[5] = '{1'b0, 32'h3FC, 32'h0,        4'b0000, 32'h12345678};
        tbl[6] = '{1'b1, 32'h40,  32'hFFFFFFFF, 4'b0000, 32'h0};
        tbl[7] = '{1'b0, 32'h40,  32'h0,        4'b0000, 32'hA5A50010};
        tbl[8] = '{1'b1, 32'h44,  32'hCAFEF00D, 4'b1100, 32'h0};
        tbl[9] = '{1'b0, 32'h44,  32'h0,        4'b0000, 32'hCAFE0011};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 32'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, rsp_valid, rsp_timeout}), 32'd0);
        chk("rst_addr",   axil.awaddr | axil.araddr, 32'd0);
        chk("rst_wdata",  axil.wdata, 32'd0);
        chk("rst_wstrb",  32'(axil.wstrb), 32'd0);
        chk("rst_rsp",    rsp_rdata | 32'(rsp_resp), 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table vectors against a zero-wait slave
        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0);
            chk($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].exp_rdata);
        end

        // wready held off 5 cycles after the address handshake
        aw_wait = 0; w_wait = 5;
        aw0 = aw_hs; w0 = w_hs; awh0 = aw_hi; wh0 = w_hi;
        do_txn(1'b1, 32'h60, 32'h0BADF00D, 4'b1111, 0);
        chk("wdelay_aw_hi_cycles", 32'(aw_hi - awh0), 32'd1);
        chk("wdelay_w_hi_cycles",  32'(w_hi - wh0), 32'd6);
        w_wait = 0;
        do_txn(1'b0, 32'h60, 32'h0, 4'b0000, 0);
        chk("wdelay_readback", g_rdata, 32'h0BADF00D);

        // Response back-pressure for 10 cycles, non-OKAY response passed through
        resp_code = 2'b11;
        do_txn(1'b0, 32'h24, 32'h0, 4'b0000, 10);
        chk("stall_rdata", g_rdata, 32'hA5A50009);
        resp_code = 2'b00;

        // Reset while awvalid is high: no write, no response
        aw_wait = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h11111111; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_mid_aw_before", 32'(axil.awvalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valids_drop", 32'({axil.awvalid, axil.wvalid}), 32'd0);
        @(negedge clk); @(negedge clk); resetn = 1'b1;
        aw_wait = 0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (rsp_valid) bad = 1'b1; end
        chk("rst_mid_no_rsp", 32'(bad), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        do_txn(1'b0, 32'h80, 32'h0, 4'b0000, 0);
        chk("rst_mid_no_write", g_rdata, 32'hA5A50020);

        // Randomized traffic with random waits, responses and back-pressure
        for (int n = 0; n < 40; n++) begin
            aw_wait   = $urandom_range(0, 3);
            w_wait    = $urandom_range(0, 3);
            ar_wait   = $urandom_range(0, 3);
            resp_code = 2'($urandom);
            do_txn(1'($urandom), 32'($urandom_range(0, 63)) << 2, $urandom, 4'($urandom),
                   $urandom_range(0, 2));
        end
        aw_wait = 0; w_wait = 0; ar_wait = 0; resp_code = 2'b00;

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Slave never accepts the read address: watchdog aborts
        ar_never = 1'b1;
        aw0 = ar_hs;
        run_cmd(1'b0, 32'h30, 32'h0, 4'b0000, 0);
        lat_exp = c_TMO + 1;
        chk("tmo_latency", 32'(g_lat), 32'(lat_exp));
        chk("tmo_resp",    32'(g_resp), 32'd2);
        chk("tmo_flag",    32'(g_tmo), 32'd1);
        chk("tmo_rdata",   g_rdata, 32'd0);
        chk("tmo_axi_idle", 32'(g_axi_at_rsp), 32'd0);
        chk("tmo_no_ar",   32'(ar_hs - aw0), 32'd0);
        ar_never = 1'b0;
        do_txn(1'b0, 32'h30, 32'h0, 4'b0000, 0);
`else
        lat_exp = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
